if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined RV32I core. It sits directly upstream of the decode stage and produces the IF/ID pipeline register contents (IF_ID_PC, IF_ID_instr) that decode consumes.
- Owns the PC.
- Issues one-outstanding requests to instruction memory over a valid/ready request and valid response interface.
- Honours hazard-unit stall and branch redirect, discarding wrong-path responses.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_id_pr.sv | 50 +++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and fetch FSM state encoding for the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_pr.sv
// ============================================================================
// Module      : if_id_pr
// Description : IF/ID pipeline register with load, hold and bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_pr
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // A bubble keeps the previous PC so decode still sees a sensible address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : RV32I instruction fetch: PC, one-outstanding imem FSM, IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        w_load;
    logic        w_bubble;
    logic [31:0] w_instr;
    logic [31:0] w_target;

    assign w_target = branch_target & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        w_load   = 1'b0;
        w_bubble = 1'b0;
        w_instr  = imem_rsp_data;

        if (branch_taken) begin
            // Redirect overrides stall; any in-flight fetch is wrong-path.
            pc_d     = w_target;
            w_bubble = 1'b1;
            unique case (state_q)
                S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stall) begin
                            hold_d  = imem_rsp_data;
                            state_d = S_HOLD;
                        end else begin
                            w_load  = 1'b1;
                            pc_d    = pc_q + 32'd4;
                            state_d = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    w_instr = hold_q;
                    if (!stall) begin
                        w_load  = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
            // With nothing to hand over, decode gets a bubble rather than a stale word.
            if (!stall && !w_load) w_bubble = 1'b1;
        end
    end

    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;

    if_id_pr #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_pr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .bubble_i (w_bubble),
        .pc_i     (pc_q),
        .instr_i  (w_instr),
        .pc_o     (IF_ID_PC),
        .instr_o  (IF_ID_instr),
        .valid_o  (IF_ID_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed per-cycle vector bench for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, imem_req_ready, imem_rsp_valid;
    logic [31:0] branch_target, imem_rsp_data;
    logic        imem_req_valid, IF_ID_valid;
    logic [31:0] imem_addr, IF_ID_PC, IF_ID_instr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_valid    (IF_ID_valid)
    );

    // One record per clock: inputs, pre-edge request outputs, post-edge IF/ID.
    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic        rdy, rspv;
        logic [31:0] rspd;
        logic        ck_addr, e_rv;
        logic [31:0] e_addr, e_pc, e_instr;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic rd, input logic rv,
                                input logic [31:0] d, input logic ca, input logic erv,
                                input logic [31:0] ea, input logic [31:0] ep,
                                input logic [31:0] ei, input logic ev);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.rdy = rd; v.rspv = rv;
        v.rspd = d; v.ck_addr = ca; v.e_rv = erv; v.e_addr = ea; v.e_pc = ep;
        v.e_instr = ei; v.e_valid = ev;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; stall = v.stall; branch_taken = v.br; branch_target = v.tgt;
        imem_req_ready = v.rdy; imem_rsp_valid = v.rspv; imem_rsp_data = v.rspd;
        #1;
        n_vec++;
        if (v.rspv && imem_req_valid && !v.rst) begin
            n_fail++;
            $display("FAIL protocol vec %0d: response driven while req_valid=1", idx);
        end
        if (imem_req_valid !== v.e_rv || (v.ck_addr && imem_addr !== v.e_addr)) begin
            n_fail++;
            $display("FAIL req vec %0d: req_valid=%b addr=%h, required req_valid=%b addr=%h",
                     idx, imem_req_valid, imem_addr, v.e_rv, v.e_addr);
        end
        @(posedge clk);
        #1;
        if (IF_ID_PC !== v.e_pc || IF_ID_instr !== v.e_instr || IF_ID_valid !== v.e_valid) begin
            n_fail++;
            $display("FAIL ifid vec %0d: pc=%h instr=%h valid=%b, required pc=%h instr=%h valid=%b",
                     idx, IF_ID_PC, IF_ID_instr, IF_ID_valid, v.e_pc, v.e_instr, v.e_valid);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        //          rst s  br tgt            rdy rv data          ca rv addr           pc             instr          v
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        NOP,          0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        NOP,          0));
        // Zero-wait fetches of 0x0, 0x4
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        32'h0,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h100,      1, 0, 32'h0,        32'h0,        32'h100,      1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h4,        32'h0,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h104,      1, 0, 32'h4,        32'h4,        32'h104,      1));
        // Ready held low for 3 cycles at 0x8
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        32'h4,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        32'h4,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        32'h4,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h8,        32'h4,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h108,      1, 0, 32'h8,        32'h8,        32'h108,      1));
        // Stall spanning the response for 0xC
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hC,        32'h8,        32'h108,      1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h10C,      1, 0, 32'hC,        32'h8,        32'h108,      1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'h8,        32'h108,      1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'h8,        32'h108,      1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hC,        32'hC,        32'h10C,      1));
        // Redirect to 0x203 while waiting; late response is dropped
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h10,       32'hC,        NOP,          0));
        tbl.push_back(mk(0, 0, 1, 32'h203,      0, 0, 32'h0,        1, 0, 32'h10,       32'hC,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h200,      32'hC,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h110,      1, 0, 32'h200,      32'hC,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h200,      32'hC,        NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h300,      1, 0, 32'h200,      32'h200,      32'h300,      1));
        // Redirect together with stall while holding a buffered word
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h204,      32'h200,      32'h300,      1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h304,      1, 0, 32'h204,      32'h200,      32'h300,      1));
        tbl.push_back(mk(0, 1, 1, 32'h400,      0, 0, 32'h0,        1, 0, 32'h204,      32'h200,      NOP,          0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h400,      32'h200,      NOP,          0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h500,      1, 0, 32'h400,      32'h400,      32'h500,      1));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // Reset while a request is outstanding, then restart from the reset PC
        run(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h404, 32'h400, NOP,     0), 100);
        run(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h404, 32'h0,   NOP,     0), 101);
        run(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 32'h0,   32'h0,   NOP,     0), 102);
        run(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h0,   32'h0,   NOP,     0), 103);
        run(mk(0, 0, 0, 32'h0,   0, 1, 32'h100, 1, 0, 32'h0,   32'h0,   32'h100, 1), 104);

        // Redirect on an accepted request, then redirect racing a response
        run(mk(0, 0, 1, 32'h800, 1, 0, 32'h0,   1, 1, 32'h4,   32'h0,   NOP,     0), 110);
        run(mk(0, 0, 0, 32'h0,   0, 1, 32'h104, 1, 0, 32'h800, 32'h0,   NOP,     0), 111);
        run(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h800, 32'h0,   NOP,     0), 112);
        run(mk(0, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'h900, 1, 0, 32'h800, 32'h0, NOP, 0), 113);

        // PC wraps past the top of the address space
        run(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,    1, 1, 32'hFFFF_FFFC, 32'h0,         NOP,      0), 120);
        run(mk(0, 0, 0, 32'h0,   0, 1, 32'hABCD, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hABCD, 1), 121);
        run(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,    1, 1, 32'h0,         32'hFFFF_FFFC, NOP,      0), 122);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
